// File: rtl/merge7_leaf_arbiter.sv
// Clocked 2:1 packet merge behind the decoder7 leaf: two small input FIFOs,
// round-robin packet-atomic arbitration, registered output and tail counter.
//
// state  | meaning
// IDLE   | no packet open; next grant picks by round-robin among non-empty FIFOs
// LOCKED | packet from lock_sel in progress; only that FIFO may load the output
module merge7_leaf_arbiter #(
  parameter int W     = 9,
  parameter int DEPTH = 2,
  parameter int CNTW  = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    in0_data,
  input  logic            in0_valid,
  output logic            in0_ready,
  input  logic [W-1:0]    in1_data,
  input  logic            in1_valid,
  output logic            in1_ready,
  output logic [W-1:0]    out_data,
  output logic            out_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CNTW-1:0] pkt_cnt
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [W-1:0] in_data [2];
  logic [W-1:0] head    [2];
  logic [1:0]   in_valid;
  logic [1:0]   in_rdy;
  logic [1:0]   nonempty;
  logic [1:0]   pop;

  logic [0:0]   state_q;
  logic         lock_sel_q;
  logic         rr_ptr_q;
  logic         grant;
  logic         sel;
  logic         load;
  logic [W-1:0] sel_flit;

  assign in_data[0] = in0_data;
  assign in_data[1] = in1_data;
  assign in_valid   = {in1_valid, in0_valid};
  assign in0_ready  = in_rdy[0];
  assign in1_ready  = in_rdy[1];

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  wr_nxt;
    logic [AW:0]  rd_nxt;
    logic         push;
    logic         rdy_q;

    assign push         = in_valid[g] & rdy_q;
    assign wr_nxt       = wr_ptr + (AW+1)'(push);
    assign rd_nxt       = rd_ptr + (AW+1)'(pop[g]);
    assign nonempty[g]  = (wr_ptr != rd_ptr);
    assign head[g]      = mem[rd_ptr[AW-1:0]];
    assign in_rdy[g]    = rdy_q;

    // Ready is registered from the post-edge pointers, so a same-cycle
    // push and pop are both reflected.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        rdy_q  <= 1'b0;
      end else begin
        wr_ptr <= wr_nxt;
        rd_ptr <= rd_nxt;
        rdy_q  <= !((wr_nxt[AW] != rd_nxt[AW]) &&
                    (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]));
      end
    end

    always_ff @(posedge clk) begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= in_data[g];
      end
    end
  end

  always_comb begin
    grant = 1'b0;
    sel   = 1'b0;
    if (state_q == LOCKED) begin
      sel   = lock_sel_q;
      grant = nonempty[lock_sel_q];
    end else if (&nonempty) begin
      sel   = rr_ptr_q;
      grant = 1'b1;
    end else if (|nonempty) begin
      sel   = nonempty[1];
      grant = 1'b1;
    end
  end

  assign load     = grant & (!out_valid | out_ready);
  assign pop      = {load & sel, load & ~sel};
  assign sel_flit = head[sel];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_sel_q <= 1'b0;
      rr_ptr_q   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_src    <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= sel_flit;
        out_src   <= sel;
        if (sel_flit[W-1]) begin
          state_q  <= IDLE;
          rr_ptr_q <= ~sel;
        end else begin
          state_q    <= LOCKED;
          lock_sel_q <= sel;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt <= '0;
    end else if (out_valid && out_ready && out_data[W-1]) begin
      pkt_cnt <= pkt_cnt + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_merge7_leaf_arbiter.sv
// Bench for merge7_leaf_arbiter: queue-based transaction model checked every
// cycle, plus directed scenarios with hand-computed output sequences.
module tb_merge7_leaf_arbiter;

  localparam int W     = 9;
  localparam int DEPTH = 2;
  localparam int CNTW  = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [W-1:0]    in0_data = '0;
  logic            in0_valid = 1'b0;
  logic            in0_ready;
  logic [W-1:0]    in1_data = '0;
  logic            in1_valid = 1'b0;
  logic            in1_ready;
  logic [W-1:0]    out_data;
  logic            out_src;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [CNTW-1:0] pkt_cnt;

  merge7_leaf_arbiter #(.W(W), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Pending stimulus per input; drivers present the head and drop it once taken
  logic [W-1:0] p0[$];
  logic [W-1:0] p1[$];
  logic acc0 = 1'b0, acc1 = 1'b0;

  initial forever begin
    @(negedge clk);
    if (acc0 && p0.size() > 0) void'(p0.pop_front());
    if (acc1 && p1.size() > 0) void'(p1.pop_front());
    if (p0.size() > 0) begin in0_valid = 1'b1; in0_data = p0[0]; end
    else in0_valid = 1'b0;
    if (p1.size() > 0) begin in1_valid = 1'b1; in1_data = p1[0]; end
    else in1_valid = 1'b0;
    acc0 = in0_valid && in0_ready && rst_n;
    acc1 = in1_valid && in1_ready && rst_n;
  end

  // Transaction model: FIFO contents as queues, one output slot, packet lock
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic [9:0]   xlog[$];
  bit           m_rdy0 = 0, m_rdy1 = 0, m_ov = 0, m_os = 0;
  bit           m_locked = 0, m_lsel = 0, m_rr = 0;
  logic [W-1:0] m_od = '0;
  int           m_cnt = 0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q0.delete(); q1.delete();
      m_rdy0 = 0; m_rdy1 = 0; m_ov = 0; m_od = '0; m_os = 0;
      m_locked = 0; m_lsel = 0; m_rr = 0; m_cnt = 0;
    end else begin
      int s;
      bit free;
      logic [W-1:0] f;
      free = !m_ov || out_ready;
      if (m_ov && out_ready) begin
        xlog.push_back({m_os, m_od});
        if (m_od[W-1]) m_cnt = (m_cnt + 1) % (1 << CNTW);
      end
      s = -1;
      if (m_locked) begin
        if (m_lsel == 0 && q0.size() > 0) s = 0;
        if (m_lsel == 1 && q1.size() > 0) s = 1;
      end else if (q0.size() > 0 && q1.size() > 0) s = int'(m_rr);
      else if (q0.size() > 0) s = 0;
      else if (q1.size() > 0) s = 1;
      if (in0_valid && m_rdy0) q0.push_back(in0_data);
      if (in1_valid && m_rdy1) q1.push_back(in1_data);
      if (free && s >= 0) begin
        f = (s == 0) ? q0.pop_front() : q1.pop_front();
        m_ov = 1; m_od = f; m_os = (s == 1);
        if (f[W-1]) begin m_locked = 0; m_rr = (s == 0); end
        else begin m_locked = 1; m_lsel = (s == 1); end
      end else if (out_ready) begin
        m_ov = 0;
      end
      m_rdy0 = q0.size() < DEPTH;
      m_rdy1 = q1.size() < DEPTH;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cyc_out_valid", 32'(out_valid), 32'(m_ov));
    if (m_ov) begin
      chk("cyc_out_data", 32'(out_data), 32'(m_od));
      chk("cyc_out_src", 32'(out_src), 32'(m_os));
    end
    chk("cyc_in0_ready", 32'(in0_ready), 32'(m_rdy0));
    chk("cyc_in1_ready", 32'(in1_ready), 32'(m_rdy1));
    chk("cyc_pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    bit done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      sync();
      done = (p0.size() == 0) && (p1.size() == 0) && (q0.size() == 0) &&
             (q1.size() == 0) && !m_ov;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL %s timeout actual=busy required=idle", name);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    p0.delete(); p1.delete();
    repeat (2) sync();
    rst_n = 1'b1;
    sync();
  endtask

  initial begin
    int n0, n1;
    logic [W-1:0] e0 [3];
    logic [W-1:0] e1 [3];

    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_src", 32'(out_src), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("rst_in0_ready", 32'(in0_ready), 0);
    chk("rst_in1_ready", 32'(in1_ready), 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_ready_pre", 32'(in0_ready), 0);
    sync();
    chk("release_in0_ready", 32'(in0_ready), 1);
    chk("release_in1_ready", 32'(in1_ready), 1);

    // Single input, 3-flit packet, back-to-back one edge after accept
    xlog.delete();
    p0.push_back(9'h005); p0.push_back(9'h006); p0.push_back(9'h107);
    sync();
    chk("single_lat_empty", 32'(out_valid), 0);
    sync();
    chk("single_first_valid", 32'(out_valid), 1);
    chk("single_first_data", 32'(out_data), 32'h005);
    sync();
    chk("single_second_data", 32'(out_data), 32'h006);
    sync();
    chk("single_tail_data", 32'(out_data), 32'h107);
    chk("single_tail_src", 32'(out_src), 0);
    wait_idle("single_idle");
    chk("single_log_len", 32'(xlog.size()), 3);
    chk("single_pkt_cnt", 32'(pkt_cnt), 1);

    // Atomicity: in1 single flit arrives while in0 packet is open
    xlog.delete();
    p0.push_back(9'h010); p0.push_back(9'h011); p0.push_back(9'h112);
    sync(); sync();
    p1.push_back(9'h1AA);
    wait_idle("atomic_idle");
    chk("atomic_log_len", 32'(xlog.size()), 4);
    if (xlog.size() == 4) begin
      chk("atomic_0", 32'(xlog[0]), 32'({1'b0, 9'h010}));
      chk("atomic_1", 32'(xlog[1]), 32'({1'b0, 9'h011}));
      chk("atomic_2", 32'(xlog[2]), 32'({1'b0, 9'h112}));
      chk("atomic_3", 32'(xlog[3]), 32'({1'b1, 9'h1AA}));
    end
    chk("atomic_pkt_cnt", 32'(pkt_cnt), 3);

    // Reset mid-packet: nothing stale afterwards
    xlog.delete();
    p0.push_back(9'h030); p0.push_back(9'h031); p0.push_back(9'h032); p0.push_back(9'h133);
    sync(); sync(); sync();
    chk("midrst_in_flight", 32'(out_valid), 1);
    rst_n = 1'b0;
    p0.delete(); p1.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_pkt_cnt", 32'(pkt_cnt), 0);
    chk("midrst_in0_ready", 32'(in0_ready), 0);
    chk("midrst_in1_ready", 32'(in1_ready), 0);
    sync();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sync();
      chk("midrst_no_stale", 32'(out_valid), 0);
    end

    // Round-robin: both inputs stream single-flit packets
    xlog.delete();
    for (int k = 0; k < 4; k++) begin
      p0.push_back(9'h100 + 9'(k));
      p1.push_back(9'h180 + 9'(k));
    end
    wait_idle("rr_idle");
    chk("rr_log_len", 32'(xlog.size()), 8);
    if (xlog.size() == 8) begin
      for (int k = 0; k < 4; k++) begin
        chk("rr_even", 32'(xlog[2*k]),   32'({1'b0, 9'h100 + 9'(k)}));
        chk("rr_odd",  32'(xlog[2*k+1]), 32'({1'b1, 9'h180 + 9'(k)}));
      end
    end

    // Backpressure: stall output for 6 cycles while both inputs send
    xlog.delete();
    e0 = '{9'h120, 9'h121, 9'h122};
    e1 = '{9'h1A0, 9'h1A1, 9'h1A2};
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      p0.push_back(e0[k]);
      p1.push_back(e1[k]);
    end
    repeat (6) sync();
    chk("bp_in0_ready", 32'(in0_ready), 0);
    chk("bp_in1_ready", 32'(in1_ready), 0);
    chk("bp_out_valid", 32'(out_valid), 1);
    chk("bp_out_held", 32'(out_data), 32'h120);
    out_ready = 1'b1;
    wait_idle("bp_idle");
    n0 = 0; n1 = 0;
    foreach (xlog[i]) begin
      if (xlog[i][9] == 1'b0) begin
        if (n0 < 3) chk("bp_order_in0", 32'(xlog[i][8:0]), 32'(e0[n0]));
        n0++;
      end else begin
        if (n1 < 3) chk("bp_order_in1", 32'(xlog[i][8:0]), 32'(e1[n1]));
        n1++;
      end
    end
    chk("bp_count_in0", 32'(n0), 3);
    chk("bp_count_in1", 32'(n1), 3);

    // Counter wrap with a 4-bit counter
    do_reset();
    for (int k = 0; k < 15; k++) p0.push_back(9'h140 + 9'(k));
    wait_idle("wrap_fill_idle");
    chk("wrap_at_max", 32'(pkt_cnt), 15);
    p1.push_back(9'h1FF);
    wait_idle("wrap_idle");
    chk("wrap_to_zero", 32'(pkt_cnt), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
